// File: rtl/decode_issue_stage.sv
// Decode/operand-fetch stage: field decode, register-file read with writeback bypass,
// RAW scoreboard stall, and a registered operand bundle toward execute.
module decode_issue_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned NREG = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [XLEN-1:0]          in_instr,
   input  logic [XLEN-1:0]          in_pc,
   output logic [$clog2(NREG)-1:0]  rf_addr_a,
   output logic [$clog2(NREG)-1:0]  rf_addr_b,
   input  logic [XLEN-1:0]          rf_data_a,
   input  logic [XLEN-1:0]          rf_data_b,
   input  logic                     wb_en,
   input  logic [$clog2(NREG)-1:0]  wb_addr,
   input  logic [XLEN-1:0]          wb_data,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [5:0]               out_op,
   output logic [5:0]               out_funct,
   output logic [$clog2(NREG)-1:0]  out_dest,
   output logic [XLEN-1:0]          out_opa,
   output logic [XLEN-1:0]          out_opb,
   output logic [XLEN-1:0]          out_imm,
   output logic [XLEN-1:0]          out_pc,
   output logic                     out_illegal
);

   localparam int unsigned AW = $clog2(NREG);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   logic [5:0]      w_op;
   logic [AW-1:0]   w_rs, w_rt, w_rd;
   logic [XLEN-1:0] w_imm;
   logic [AW-1:0]   w_dest;
   logic            w_use_b, w_illegal;
   logic [XLEN-1:0] w_opa, w_opb;
   logic            w_haz_a, w_haz_b, w_stall;
   logic            w_fire, w_out_hs;
   logic [NREG-1:0] w_busy_d;

   logic [NREG-1:0] r_busy;
   logic            r_valid;
   logic [5:0]      r_op, r_funct;
   logic [AW-1:0]   r_dest;
   logic [XLEN-1:0] r_opa, r_opb, r_imm, r_pc;
   logic            r_illegal;

   assign w_op  = in_instr[31:26];
   assign w_rs  = in_instr[25:21];
   assign w_rt  = in_instr[20:16];
   assign w_rd  = in_instr[15:11];
   assign w_imm = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};

   assign rf_addr_a = w_rs;
   assign rf_addr_b = w_rt;

   always_comb begin
      w_dest    = '0;
      w_use_b   = 1'b0;
      w_illegal = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            w_dest  = w_rd;
            w_use_b = 1'b1;
         end
         OP_ADDI, OP_LW: w_dest = w_rt;
         OP_SW, OP_BEQ:  w_use_b = 1'b1;
         default:        w_illegal = 1'b1;
      endcase
   end

   // r0 reads as zero; a same-cycle writeback beats the register file's stale value
   always_comb begin
      if (w_rs == '0)                      w_opa = '0;
      else if (wb_en && (wb_addr == w_rs)) w_opa = wb_data;
      else                                 w_opa = rf_data_a;
      if (w_rt == '0)                      w_opb = '0;
      else if (wb_en && (wb_addr == w_rt)) w_opb = wb_data;
      else                                 w_opb = rf_data_b;
   end

   // A pending producer blocks unless it is being written back right now; a producer still
   // held in the output register has not set its busy bit yet, so it is checked directly.
   assign w_haz_a = (w_rs != '0) &&
                    ((r_busy[w_rs] && !(wb_en && (wb_addr == w_rs))) ||
                     (r_valid && (r_dest == w_rs)));
   assign w_haz_b = w_use_b && (w_rt != '0) &&
                    ((r_busy[w_rt] && !(wb_en && (wb_addr == w_rt))) ||
                     (r_valid && (r_dest == w_rt)));
   assign w_stall = w_haz_a || w_haz_b;

   assign in_ready = !w_stall && (!r_valid || out_ready) && !flush;
   assign w_fire   = in_valid && in_ready;
   assign w_out_hs = r_valid && out_ready;

   // Set is applied after clear so an issuing producer wins over a same-cycle writeback
   always_comb begin
      w_busy_d = r_busy;
      if (wb_en) w_busy_d[wb_addr] = 1'b0;
      if (w_out_hs) w_busy_d[r_dest] = 1'b1;
      w_busy_d[0] = 1'b0;
      if (flush) w_busy_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy    <= '0;
         r_valid   <= 1'b0;
         r_op      <= '0;
         r_funct   <= '0;
         r_dest    <= '0;
         r_opa     <= '0;
         r_opb     <= '0;
         r_imm     <= '0;
         r_pc      <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_busy <= w_busy_d;
         if (flush) begin
            r_valid <= 1'b0;
         end else if (w_fire) begin
            r_valid   <= 1'b1;
            r_op      <= w_op;
            r_funct   <= in_instr[5:0];
            r_dest    <= w_dest;
            r_opa     <= w_opa;
            r_opb     <= w_opb;
            r_imm     <= w_imm;
            r_pc      <= in_pc;
            r_illegal <= w_illegal;
         end else if (out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid   = r_valid;
   assign out_op      = r_op;
   assign out_funct   = r_funct;
   assign out_dest    = r_dest;
   assign out_opa     = r_opa;
   assign out_opb     = r_opb;
   assign out_imm     = r_imm;
   assign out_pc      = r_pc;
   assign out_illegal = r_illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: decode vector table, hand-written hazard/flush/reset
// sequences, then randomized traffic against a scoreboard-level reference model.
module tb_decode_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_instr, in_pc;
   logic [4:0]  rf_addr_a, rf_addr_b;
   logic [31:0] rf_data_a, rf_data_b;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [5:0]  out_op, out_funct;
   logic [4:0]  out_dest;
   logic [31:0] out_opa, out_opb, out_imm, out_pc;
   logic        out_illegal;

   logic [31:0] rf [32];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign rf_data_a = rf[rf_addr_a];
   assign rf_data_b = rf[rf_addr_b];

   decode_issue_stage #(.XLEN(32), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
      .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_funct(out_funct),
      .out_dest(out_dest), .out_opa(out_opa), .out_opb(out_opb), .out_imm(out_imm),
      .out_pc(out_pc), .out_illegal(out_illegal)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      wb_en     = 1'b0;
      wb_addr   = '0;
      wb_data   = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic do_flush();
      in_valid = 1'b0;
      wb_en    = 1'b0;
      flush    = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic chk_rdy(input string name, input logic exp);
      @(negedge clk);
      check(name, {31'd0, in_ready}, {31'd0, exp});
   endtask

   // ---------------- reference model ----------------
   bit          m_busy [32];
   logic        m_valid;
   logic [4:0]  m_dest;
   logic [31:0] m_opa, m_opb, m_imm, m_pc;
   logic [5:0]  m_op, m_funct;
   logic        m_ill;

   function automatic void exp_decode(input logic [31:0] ins, output logic [4:0] d,
                                      output logic ub, output logic il);
      d = 5'd0; ub = 1'b0; il = 1'b0;
      case (ins[31:26])
         6'h00: begin d = ins[15:11]; ub = 1'b1; end
         6'h08, 6'h23: d = ins[20:16];
         6'h2B, 6'h04: ub = 1'b1;
         default: il = 1'b1;
      endcase
   endfunction

   function automatic logic src_blocked(input logic [4:0] s);
      if (s == 5'd0) return 1'b0;
      if (m_valid && m_dest == s) return 1'b1;
      return m_busy[s] && !(wb_en && wb_addr == s);
   endfunction

   function automatic logic [31:0] exp_opnd(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_en && wb_addr == a) return wb_data;
      return rf[a];
   endfunction

   // ---------------- decode table ----------------
   typedef struct {
      logic [31:0] instr;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [4:0]  dest;
      logic [31:0] opa, opb, imm;
      logic        ill;
   } vec_t;

   vec_t vecs [9];

   initial begin
      logic [4:0]  d, rs_v, rt_v;
      logic        ub, il, stall, exp_rdy, fire, hs;
      logic [31:0] ins;

      for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
      vecs[0] = '{{6'h08, 5'd0, 5'd3, 16'hFFFB}, 1'b0, 5'd0, 32'h0, 5'd3,
                  32'h0, 32'h103, 32'hFFFFFFFB, 1'b0};
      vecs[1] = '{{6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h20}, 1'b0, 5'd0, 32'h0, 5'd4,
                  32'h101, 32'h102, 32'h00002020, 1'b0};
      vecs[2] = '{{6'h23, 5'd5, 5'd7, 16'h8000}, 1'b0, 5'd0, 32'h0, 5'd7,
                  32'h105, 32'h107, 32'hFFFF8000, 1'b0};
      vecs[3] = '{{6'h2B, 5'd6, 5'd9, 16'h0004}, 1'b0, 5'd0, 32'h0, 5'd0,
                  32'h106, 32'h109, 32'h00000004, 1'b0};
      vecs[4] = '{{6'h04, 5'd1, 5'd1, 16'hFFFF}, 1'b0, 5'd0, 32'h0, 5'd0,
                  32'h101, 32'h101, 32'hFFFFFFFF, 1'b0};
      vecs[5] = '{{6'h3F, 5'd2, 5'd3, 5'd4, 11'h0}, 1'b0, 5'd0, 32'h0, 5'd0,
                  32'h102, 32'h103, 32'h00002000, 1'b1};
      vecs[6] = '{{6'h08, 5'd2, 5'd5, 16'h0001}, 1'b1, 5'd2, 32'hDEADBEEF, 5'd5,
                  32'hDEADBEEF, 32'h105, 32'h00000001, 1'b0};
      vecs[7] = '{{6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21}, 1'b1, 5'd2, 32'h55, 5'd0,
                  32'h101, 32'h55, 32'h00000021, 1'b0};
      vecs[8] = '{{6'h08, 5'd0, 5'd1, 16'h0007}, 1'b1, 5'd0, 32'hFFFF, 5'd1,
                  32'h0, 32'h101, 32'h00000007, 1'b0};

      // ---- reset then idle ----
      set_idle();
      rst_n = 1'b0;
      #12;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_dest", {27'd0, out_dest}, 32'd0);
      check("rst_opa", out_opa, 32'd0);
      check("rst_imm", out_imm, 32'd0);
      check("rst_pc", out_pc, 32'd0);
      check("rst_illegal", {31'd0, out_illegal}, 32'd0);
      rst_n = 1'b1;
      chk_rdy("idle_ready", 1'b1);
      tick();

      // ---- decode table ----
      for (int i = 0; i < 9; i++) begin
         in_instr = vecs[i].instr;
         in_pc    = 32'h400 + 32'(i) * 4;
         wb_en    = vecs[i].wen;
         wb_addr  = vecs[i].waddr;
         wb_data  = vecs[i].wdata;
         in_valid = 1'b1;
         chk_rdy($sformatf("vec%0d_ready", i), 1'b1);
         tick();
         in_valid = 1'b0;
         wb_en    = 1'b0;
         ins      = vecs[i].instr;
         check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check($sformatf("vec%0d_op", i), {26'd0, out_op}, {26'd0, ins[31:26]});
         check($sformatf("vec%0d_funct", i), {26'd0, out_funct}, {26'd0, ins[5:0]});
         check($sformatf("vec%0d_dest", i), {27'd0, out_dest}, {27'd0, vecs[i].dest});
         check($sformatf("vec%0d_opa", i), out_opa, vecs[i].opa);
         check($sformatf("vec%0d_opb", i), out_opb, vecs[i].opb);
         check($sformatf("vec%0d_imm", i), out_imm, vecs[i].imm);
         check($sformatf("vec%0d_pc", i), out_pc, 32'h400 + 32'(i) * 4);
         check($sformatf("vec%0d_ill", i), {31'd0, out_illegal}, {31'd0, vecs[i].ill});
         do_flush();
      end

      // ---- back-to-back RAW resolved by writeback bypass ----
      in_instr = {6'h08, 5'd0, 5'd3, 16'hFFFB};
      in_valid = 1'b1;
      chk_rdy("raw_first_ready", 1'b1);
      tick();
      in_instr = {6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20};
      chk_rdy("raw_held_stall", 1'b0);
      tick();
      check("raw_gone_valid", {31'd0, out_valid}, 32'd0);
      chk_rdy("raw_busy_stall", 1'b0);
      tick();
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd7;
      chk_rdy("raw_wb_ready", 1'b1);
      tick();
      wb_en = 1'b0; in_valid = 1'b0;
      check("raw_out_valid", {31'd0, out_valid}, 32'd1);
      check("raw_opa", out_opa, 32'd7);
      check("raw_opb", out_opb, 32'd7);
      check("raw_dest", {27'd0, out_dest}, 32'd4);
      do_flush();

      // ---- backpressure ----
      in_instr = {6'h08, 5'd0, 5'd3, 16'hFFFB};
      in_valid = 1'b1;
      tick();
      out_ready = 1'b0;
      in_instr  = {6'h08, 5'd1, 5'd6, 16'h0002};
      for (int k = 0; k < 3; k++) begin
         chk_rdy($sformatf("bp%0d_ready", k), 1'b0);
         tick();
         check($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
         check($sformatf("bp%0d_dest", k), {27'd0, out_dest}, 32'd3);
         check($sformatf("bp%0d_imm", k), out_imm, 32'hFFFFFFFB);
      end
      out_ready = 1'b1;
      chk_rdy("bp_release_ready", 1'b1);
      tick();
      in_valid = 1'b0;
      check("bp_next_valid", {31'd0, out_valid}, 32'd1);
      check("bp_next_dest", {27'd0, out_dest}, 32'd6);
      check("bp_next_opa", out_opa, 32'h101);
      do_flush();

      // ---- set/clear collision: set wins ----
      in_instr = {6'h08, 5'd0, 5'd5, 16'h0001};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
      tick();
      wb_en    = 1'b0;
      in_instr = {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h20};
      in_valid = 1'b1;
      check("col_valid", {31'd0, out_valid}, 32'd0);
      chk_rdy("col_stall", 1'b0);
      tick();
      wb_en = 1'b1; wb_addr = 5'd5;
      chk_rdy("col_wb_ready", 1'b1);
      tick();
      in_valid = 1'b0; wb_en = 1'b0;
      check("col_fire_opa", out_opa, 32'h1234);
      do_flush();

      // ---- flush with held bundle and busy r3 ----
      in_instr = {6'h08, 5'd0, 5'd3, 16'h0001};
      in_valid = 1'b1;
      tick();
      in_instr = {6'h08, 5'd0, 5'd8, 16'h0000};
      chk_rdy("fl_indep_ready", 1'b1);
      tick();
      flush = 1'b1; out_ready = 1'b0;
      in_instr = {6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20};
      chk_rdy("fl_flush_ready", 1'b0);
      tick();
      flush = 1'b0; out_ready = 1'b1;
      check("fl_valid", {31'd0, out_valid}, 32'd0);
      chk_rdy("fl_reader_ready", 1'b1);
      tick();
      in_valid = 1'b0;
      check("fl_reader_valid", {31'd0, out_valid}, 32'd1);
      check("fl_reader_dest", {27'd0, out_dest}, 32'd4);
      do_flush();

      // ---- illegal opcode leaves nothing busy ----
      in_instr = {6'h3F, 5'd0, 5'd3, 5'd3, 11'h0};
      in_valid = 1'b1;
      tick();
      check("ill_flag", {31'd0, out_illegal}, 32'd1);
      check("ill_dest", {27'd0, out_dest}, 32'd0);
      in_instr = {6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20};
      chk_rdy("ill_reader_ready", 1'b1);
      tick();
      in_valid = 1'b0;
      check("ill_reader_dest", {27'd0, out_dest}, 32'd4);
      do_flush();

      // ---- randomized traffic vs model ----
      foreach (m_busy[k]) m_busy[k] = 1'b0;
      m_valid = 1'b0;
      m_dest = '0; m_opa = '0; m_opb = '0; m_imm = '0; m_pc = '0;
      m_op = '0; m_funct = '0; m_ill = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         case ($urandom_range(0, 6))
            0: ins[31:26] = 6'h00;
            1: ins[31:26] = 6'h08;
            2: ins[31:26] = 6'h23;
            3: ins[31:26] = 6'h2B;
            4: ins[31:26] = 6'h04;
            5: ins[31:26] = 6'h3F;
            default: ins[31:26] = 6'($urandom);
         endcase
         ins[25:21] = 5'($urandom_range(0, 7));
         ins[20:16] = 5'($urandom_range(0, 7));
         ins[15:11] = 5'($urandom_range(0, 7));
         ins[10:0]  = 11'($urandom);
         in_instr  = ins;
         in_pc     = $urandom;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         wb_en     = ($urandom_range(0, 2) == 0);
         wb_addr   = 5'($urandom_range(0, 7));
         wb_data   = $urandom;
         flush     = ($urandom_range(0, 40) == 0);

         @(negedge clk);
         exp_decode(ins, d, ub, il);
         rs_v = ins[25:21];
         rt_v = ins[20:16];
         stall   = src_blocked(rs_v) || (ub && src_blocked(rt_v));
         exp_rdy = !stall && (!m_valid || out_ready) && !flush;
         check("rnd_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         check("rnd_addr_a", {27'd0, rf_addr_a}, {27'd0, rs_v});
         check("rnd_addr_b", {27'd0, rf_addr_b}, {27'd0, rt_v});
         fire = in_valid && exp_rdy;
         hs   = m_valid && out_ready;
         if (flush) begin
            foreach (m_busy[k]) m_busy[k] = 1'b0;
            m_valid = 1'b0;
         end else begin
            if (wb_en && wb_addr != 5'd0) m_busy[wb_addr] = 1'b0;
            if (hs && m_dest != 5'd0) m_busy[m_dest] = 1'b1;
            if (fire) begin
               m_valid = 1'b1;
               m_op    = ins[31:26];
               m_funct = ins[5:0];
               m_dest  = d;
               m_opa   = exp_opnd(rs_v);
               m_opb   = exp_opnd(rt_v);
               m_imm   = {{16{ins[15]}}, ins[15:0]};
               m_pc    = in_pc;
               m_ill   = il;
            end else if (hs) begin
               m_valid = 1'b0;
            end
         end
         tick();
         check("rnd_valid", {31'd0, out_valid}, {31'd0, m_valid});
         if (m_valid) begin
            check("rnd_op", {26'd0, out_op}, {26'd0, m_op});
            check("rnd_funct", {26'd0, out_funct}, {26'd0, m_funct});
            check("rnd_dest", {27'd0, out_dest}, {27'd0, m_dest});
            check("rnd_opa", out_opa, m_opa);
            check("rnd_opb", out_opb, m_opb);
            check("rnd_imm", out_imm, m_imm);
            check("rnd_pc", out_pc, m_pc);
            check("rnd_ill", {31'd0, out_illegal}, {31'd0, m_ill});
         end
      end
      set_idle();
      do_flush();

      // ---- asynchronous reset mid-stall ----
      in_instr  = {6'h08, 5'd0, 5'd3, 16'h0009};
      in_pc     = 32'h800;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_instr  = {6'h00, 5'd3, 5'd3, 5'd4, 5'd0, 6'h20};
      chk_rdy("ar_stall", 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid", {31'd0, out_valid}, 32'd0);
      check("ar_dest", {27'd0, out_dest}, 32'd0);
      check("ar_imm", out_imm, 32'd0);
      check("ar_pc", out_pc, 32'd0);
      check("ar_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Decode/operand-fetch stage sitting directly upstream of the 32x32 `register` file.
- Takes 32-bit instructions from fetch and decodes the fields.
- Drives the register file's two combinational read ports and forwards same-cycle writebacks.
- Tracks pending destination writes in a scoreboard, stalls on RAW hazards, and hands a registered operand bundle to execute through a valid/ready handshake.

Parameters:
- XLEN, 32, data/instruction width
- NREG, 32, architectural registers; address width is log2(NREG) = 5

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- rf_addr_a  out  5  register file read address A; equals in_instr[25:21], combinational
- rf_addr_b  out  5  register file read address B; equals in_instr[20:16], combinational
- rf_data_a  in  32  register file read data A (combinational read)
- rf_data_b  in  32  register file read data B
- wb_en  in  1  writeback this cycle
- wb_addr  in  5  writeback register
- wb_data  in  32  writeback data
- flush  in  1  discard held instruction and clear scoreboard
- out_valid  out  1  bundle valid
- out_ready  in  1  execute accepts bundle
- out_op  out  6  opcode
- out_funct  out  6  funct field (in_instr[5:0])
- out_dest  out  5  destination register; 0 if the instruction does not write
- out_opa  out  32  operand A
- out_opb  out  32  operand B
- out_imm  out  32  sign-extended in_instr[15:0]
- out_pc  out  32  pc
- out_illegal  out  1  opcode not recognised

Behaviour:
- Field layout:
  - op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11].
  - imm = [15:0], sign-extended with bit 15 replicated.
- Destination by opcode:
  - 0x00 (R-type) -> rd.
  - 0x08 (ADDI), 0x23 (LW) -> rt.
  - 0x2B (SW), 0x04 (BEQ) -> 0.
  - Any other opcode -> out_illegal=1, dest 0.
  - A computed dest of 0 is forced to 0 (r0 is never tracked).
- Sources:
  - A = rs always.
  - B = rt for R-type, SW and BEQ only; ADDI and LW do not use B for hazard checks, but out_opb still carries the rt value.
- Operand selection per port:
  - Address 0 -> 0.
  - Else if wb_en and wb_addr matches -> wb_data (bypass).
  - Else -> rf_data.
- Scoreboard: busy[31:0], busy[0] hardwired 0.
  - Set busy[out_dest] on the output handshake (out_valid & out_ready).
  - Clear busy[wb_addr] on wb_en.
  - Set and clear of the same register in one cycle -> set wins.
- Hazard (stall) when a used source s != 0 and either:
  - busy[s] is set and not (wb_en and wb_addr == s); or
  - out_valid=1 and out_dest == s (the producer is still held in this stage).
- Handshake:
  - in_ready = !stall & (!out_valid | out_ready) & !flush. Combinational; only stall depends on in_instr.
  - Fire (in_valid & in_ready) loads all out_* registers and sets out_valid=1 at the next edge.
  - Output handshake without a new fire -> out_valid=0.
  - While out_valid=1 and out_ready=0, every out_* field holds stable.
- Latency: 1 cycle from fire to out_valid.
- Flush: at the next edge out_valid=0 and busy cleared entirely. Wins over a simultaneous fire, set or clear.
- Reset (async, rst_n=0): out_valid=0, busy=0, all out_* data fields 0, out_illegal=0. Reset mid-stall drops the held bundle.
- wb_addr=0 with wb_en=1 has no effect.

Test Plan:
- Reset then idle: all outputs 0, in_ready=1 with in_valid=0. Fire ADDI r3,r0,-5 -> next cycle out_valid=1, out_dest=3, out_imm=0xFFFFFFFB, out_opa=0.
- Back-to-back RAW: ADDI r3 then R-type add r4,r3,r3 with out_ready=1 -> second stalls (in_ready=0) until wb_en with wb_addr=3, wb_data=7. In that cycle in_ready=1 and out_opa=out_opb=7.
- Backpressure: out_ready=0 for 3 cycles -> out_* stable and in_ready=0. Independent instruction fires the cycle out_ready returns to 1.
- Set/clear collision: ADDI r5 leaves the stage (handshake) while wb_en clears r5 in the same cycle -> busy[5]=1 afterwards, and a following reader of r5 stalls.
- Flush while out_valid=1 and busy[3]=1 -> next cycle out_valid=0 and busy=0, and a reader of r3 fires immediately.
- Illegal opcode 0x3F -> out_illegal=1, out_dest=0, no busy bit set. Assert rst_n low mid-stall -> outputs 0 immediately, without waiting for a clock edge.
